// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, idle line level.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_LINE_IDLE = 1'b1;

    // Frame sequencing states; PARITY is only entered when TX_PARITY_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity bit: XOR of all data bits
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-duration timer: 16-bit counter that pulses tc on the last cycle of a
// CLK_PER_BIT-long bit and wraps to zero on its own, so consecutive bits need
// no reload. clr restarts the count at the beginning of a frame.
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [15:0] TC_VAL = 16'(CLK_PER_BIT - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == TC_VAL);

    // Next count: clear on request, otherwise count and wrap at terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tc ? 16'd0 : cnt_q + 16'd1;
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity,
// STOP_BITS stop bits. Every bit lasts CLK_PER_BIT baud_clk cycles.
// Define TX_PARITY_EN to insert an even-parity bit between data and stop.
// All outputs are registered; reset forces the line idle immediately.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 2,
    parameter int STOP_BITS   = 1
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      tmr_clr, tmr_tc;

    // Timer runs in every non-idle state and restarts on frame accept
    uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
        .clk (baud_clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (state_q != ST_IDLE),
        .tc  (tmr_tc)
    );

    // Next-state logic; tx_d holds the level of the bit being entered so the
    // line changes exactly on the transition edge. bit_idx also counts stop bits.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmr_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d   = UART_LINE_IDLE;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d   = tx_data;
                    state_d   = ST_START;
                    busy_d    = 1'b1;
                    tx_d      = 1'b0;
                    bit_idx_d = '0;
                    tmr_clr   = 1'b1;
                end
            end
            ST_START: begin
                if (tmr_tc) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tmr_tc) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = even_parity(shift_q);
`else
                        state_d = ST_STOP;
                        tx_d    = UART_LINE_IDLE;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                if (tmr_tc) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_d      = UART_LINE_IDLE;
                end
            end
`endif
            ST_STOP: begin
                if (tmr_tc) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = UART_LINE_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                tx_d    = UART_LINE_IDLE;
            end
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= UART_LINE_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: instance A (CLK_PER_BIT=2, STOP_BITS=1) and
// instance B (CLK_PER_BIT=3, STOP_BITS=2). Expected bytes are queued when a
// frame is requested and checked bit by bit as the frame comes out.
module tb_uart_transmitter;

`ifdef TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       baud_clk;
    logic       rst;
    logic       tx_start_a, tx_start_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_a, tx_busy_a, tx_done_a;
    logic       tx_b, tx_busy_b, tx_done_b;
    logic       sel;
    logic       m_tx, m_busy, m_done;

    int         total = 0;
    int         bad = 0;
    int         done_cnt_a = 0;
    logic [7:0] exp_q[$];

    uart_transmitter #(.CLK_PER_BIT(2), .STOP_BITS(1)) dut_a (
        .baud_clk (baud_clk),
        .rst      (rst),
        .tx_start (tx_start_a),
        .tx_data  (tx_data_a),
        .tx       (tx_a),
        .tx_busy  (tx_busy_a),
        .tx_done  (tx_done_a)
    );

    uart_transmitter #(.CLK_PER_BIT(3), .STOP_BITS(2)) dut_b (
        .baud_clk (baud_clk),
        .rst      (rst),
        .tx_start (tx_start_b),
        .tx_data  (tx_data_b),
        .tx       (tx_b),
        .tx_busy  (tx_busy_b),
        .tx_done  (tx_done_b)
    );

    assign m_tx   = sel ? tx_b      : tx_a;
    assign m_busy = sel ? tx_busy_b : tx_busy_a;
    assign m_done = sel ? tx_done_b : tx_done_a;

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) if (tx_done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

    // Expected line level for frame bit position p of byte d
    function automatic logic exp_level(input logic [7:0] d, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return d[p-1];
        if (PAR == 1 && p == 9) return ^d;
        return 1'b1;
    endfunction

    // Scoreboard: pop the next expected byte and check the frame now on the
    // selected instance, ending at the negedge where tx_done is high
    task automatic sb_check_frame(input string nm, input int cpb, input int nstop);
        logic [7:0] d;
        int         nb;
        bit         got;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_queue: scoreboard empty, required one pending byte", nm);
            return;
        end
        d = exp_q.pop_front();
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_busy === 1'b1) begin got = 1; break; end
            @(negedge baud_clk);
        end
        if (!got) begin
            bad++;
            $display("FAIL %s_accept: tx_busy=%b required 1", nm, m_busy);
            return;
        end
        nb = 9 + PAR + nstop;
        for (int k = 0; k < nb * cpb; k++) begin
            total++;
            if (m_tx !== exp_level(d, k / cpb) || m_busy !== 1'b1 || m_done !== 1'b0) begin
                bad++;
                $display("FAIL %s_bit cycle %0d: tx=%b busy=%b done=%b required tx=%b busy=1 done=0",
                         nm, k, m_tx, m_busy, m_done, exp_level(d, k / cpb));
            end
            @(negedge baud_clk);
        end
        total++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_tx !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: done=%b busy=%b tx=%b required done=1 busy=0 tx=1",
                     nm, m_done, m_busy, m_tx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge baud_clk);
        total++;
        if ({tx_a, tx_busy_a, tx_done_a, tx_b, tx_busy_b, tx_done_b} !== 6'b100100) begin
            bad++;
            $display("FAIL reset_state: a=%b%b%b b=%b%b%b required tx/busy/done=100",
                     tx_a, tx_busy_a, tx_done_a, tx_b, tx_busy_b, tx_done_b);
        end
        rst = 1'b0;
        @(negedge baud_clk);
    endtask

    task automatic test_basic(input logic [7:0] d, input string nm);
        sel = 1'b0;
        tx_start_a = 1'b1; tx_data_a = d; exp_q.push_back(d);
        @(negedge baud_clk);
        tx_start_a = 1'b0;
        sb_check_frame(nm, 2, 1);
        @(negedge baud_clk);
        total++;
        if (tx_done_a !== 1'b0 || tx_a !== 1'b1) begin
            bad++;
            $display("FAIL %s_pulse: done=%b tx=%b required done=0 tx=1", nm, tx_done_a, tx_a);
        end
    endtask

    task automatic test_ignore_busy();
        sel = 1'b0;
        tx_start_a = 1'b1; tx_data_a = 8'h3C; exp_q.push_back(8'h3C);
        @(negedge baud_clk);
        tx_data_a = 8'hFF;
        sb_check_frame("ignore", 2, 1);
        tx_start_a = 1'b0;
        @(negedge baud_clk);
        total++;
        if (tx_busy_a !== 1'b0 || tx_a !== 1'b1) begin
            bad++;
            $display("FAIL ignore_idle: busy=%b tx=%b required busy=0 tx=1", tx_busy_a, tx_a);
        end
        @(negedge baud_clk);
    endtask

    task automatic test_back_to_back();
        int c0;
        sel = 1'b0;
        c0 = done_cnt_a;
        tx_start_a = 1'b1; tx_data_a = 8'h00;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        @(negedge baud_clk);
        tx_data_a = 8'hFF;
        sb_check_frame("b2b_first", 2, 1);
        @(negedge baud_clk);
        total++;
        if (tx_busy_a !== 1'b1 || tx_a !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: busy=%b tx=%b required busy=1 tx=0", tx_busy_a, tx_a);
        end
        tx_start_a = 1'b0;
        sb_check_frame("b2b_second", 2, 1);
        @(negedge baud_clk);
        total++;
        if (done_cnt_a !== c0 + 2) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d required %0d", done_cnt_a - c0, 2);
        end
    endtask

    task automatic test_reset_midframe();
        int c0;
        sel = 1'b0;
        tx_start_a = 1'b1; tx_data_a = 8'h81;
        @(negedge baud_clk);
        tx_start_a = 1'b0;
        repeat (7) @(negedge baud_clk);
        total++;
        if (tx_a !== 1'b0 || tx_busy_a !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: tx=%b busy=%b required tx=0 busy=1", tx_a, tx_busy_a);
        end
        c0 = done_cnt_a;
        #2 rst = 1'b1;
        #1;
        total++;
        if (tx_a !== 1'b1 || tx_busy_a !== 1'b0 || tx_done_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: tx=%b busy=%b done=%b required 1 0 0", tx_a, tx_busy_a, tx_done_a);
        end
        @(negedge baud_clk);
        rst = 1'b0;
        repeat (25) @(negedge baud_clk);
        total++;
        if (done_cnt_a !== c0 || tx_busy_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_done: done pulses=%0d busy=%b required 0 0", done_cnt_a - c0, tx_busy_a);
        end
        test_basic(8'h55, "after_rst");
    endtask

    task automatic test_two_stop();
        sel = 1'b1;
        tx_start_b = 1'b1; tx_data_b = 8'h01; exp_q.push_back(8'h01);
        @(negedge baud_clk);
        tx_start_b = 1'b0;
        sb_check_frame("stop2", 3, 2);
        @(negedge baud_clk);
        total++;
        if (tx_done_b !== 1'b0 || tx_busy_b !== 1'b0) begin
            bad++;
            $display("FAIL stop2_idle: done=%b busy=%b required 0 0", tx_done_b, tx_busy_b);
        end
        sel = 1'b0;
    endtask

    task automatic test_parity();
        test_basic(8'hA5, "par_a5");
        test_basic(8'h07, "par_07");
    endtask

    initial begin
        sel = 1'b0;
        tx_start_a = 1'b0; tx_data_a = 8'h00;
        tx_start_b = 1'b0; tx_data_b = 8'h00;
        test_reset();
        test_basic(8'hA5, "a5");
        test_ignore_busy();
        test_back_to_back();
        test_reset_midframe();
        test_two_stop();
        test_parity();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d bytes pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
